mem_stage_lsu: RTL and testbench

- Memory-access stage of the 5-stage RV32 pipeline. Sits between the EX/MEM register and the MEM/WB register.
- Issues load/store requests to the data-memory port using a valid/ready request handshake and a separate read-data-valid return.
- Aligns and extends load data, and holds the pipeline through a global stall until each access completes.
- Produces the writeback-side fields (load data, ALU result, rd, regwrite, memtoreg, floatwb) that the MEM/WB register captures.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/mem_load_align.sv | 28 ++
 rtl/mem_stage_lsu.sv | 168 ++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared funct3 encodings, LSU state type and alignment rule for the memory stage.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_t;

  // funct3[1:0] carries the access size for both loads and stores.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    logic mis;
    case (funct3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/half/word lane of a read word and sign- or zero-extends it.
// Purely combinational.
module mem_load_align
  import mem_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [2:0]    funct3,
  input  logic [1:0]    off,
  input  logic [DW-1:0] rdata,
  output logic [DW-1:0] data
);

  logic [DW-1:0] shifted;

  always_comb begin
    shifted = rdata >> {off, 3'b000};
    case (funct3)
      F3_B:    data = {{(DW-8){shifted[7]}}, shifted[7:0]};
      F3_BU:   data = {{(DW-8){1'b0}}, shifted[7:0]};
      F3_H:    data = {{(DW-16){shifted[15]}}, shifted[15:0]};
      F3_HU:   data = {{(DW-16){1'b0}}, shifted[15:0]};
      F3_W:    data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage load/store unit: one request per access, stall held until DONE (>=2 cycles aligned, 1 misaligned).
// Request waits on dm_ready; loads then wait on dm_rvalid, which may coincide with dm_ready.
module mem_stage_lsu
  import mem_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            ex_memread,
  input  logic            ex_memwrite,
  input  logic [2:0]      ex_funct3,
  input  logic [AW-1:0]   ex_addr,
  input  logic [DW-1:0]   ex_wdata,
  input  logic [DW-1:0]   ex_aluout,
  input  logic [4:0]      ex_rd,
  input  logic            ex_regwrite,
  input  logic            ex_memtoreg,
  input  logic            ex_floatwb,
  output logic            dm_req,
  input  logic            dm_ready,
  output logic [DW/8-1:0] dm_we,
  output logic [AW-1:0]   dm_addr,
  output logic [DW-1:0]   dm_wdata,
  input  logic            dm_rvalid,
  input  logic [DW-1:0]   dm_rdata,
  output logic            mem_stall,
  output logic            mem_misalign,
  output logic [DW-1:0]   wb_data,
  output logic [DW-1:0]   wb_aluout,
  output logic [4:0]      wb_rd,
  output logic            wb_regwrite,
  output logic            wb_memtoreg,
  output logic            wb_floatwb
);

  lsu_state_t state, state_nx;

  logic [1:0]      off;
  logic            mem_op;
  logic            mis;
  logic            req_start;
  logic            mis_start;
  logic            ld_capture;
  logic            mis_q;
  logic [DW-1:0]   ld_aligned;
  logic [DW-1:0]   ld_q;
  logic [DW/8-1:0] st_we;
  logic [DW-1:0]   st_wdata;

  assign off    = ex_addr[1:0];
  assign mem_op = ex_valid & (ex_memread | ex_memwrite);
  assign mis    = is_misaligned(ex_funct3, off);

  mem_load_align #(.DW(DW)) u_load_align (
    .funct3 (ex_funct3),
    .off    (off),
    .rdata  (dm_rdata),
    .data   (ld_aligned)
  );

  // Store data is replicated across all lanes; the strobes pick the live ones.
  always_comb begin
    st_we    = '0;
    st_wdata = ex_wdata;
    if (ex_memwrite) begin
      case (ex_funct3[1:0])
        2'b00: begin
          st_we    = 4'b0001 << off;
          st_wdata = {4{ex_wdata[7:0]}};
        end
        2'b01: begin
          st_we    = 4'b0011 << off;
          st_wdata = {2{ex_wdata[15:0]}};
        end
        default: begin
          st_we    = 4'b1111;
          st_wdata = ex_wdata;
        end
      endcase
    end
  end

  always_comb begin
    state_nx   = state;
    req_start  = 1'b0;
    mis_start  = 1'b0;
    ld_capture = 1'b0;
    mem_stall  = 1'b0;
    dm_req     = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          mem_stall = 1'b1;
          if (mis) begin
            mis_start = 1'b1;
            state_nx  = DONE;
          end else begin
            req_start = 1'b1;
            state_nx  = REQ;
          end
        end
      end
      REQ: begin
        mem_stall = 1'b1;
        dm_req    = 1'b1;
        if (dm_ready) begin
          if (ex_memwrite) begin
            state_nx = DONE;
          end else if (dm_rvalid) begin
            ld_capture = 1'b1;
            state_nx   = DONE;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        mem_stall = 1'b1;
        if (dm_rvalid) begin
          ld_capture = 1'b1;
          state_nx   = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Request fields are launched from IDLE so they are stable for the whole REQ phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dm_addr  <= '0;
      dm_we    <= '0;
      dm_wdata <= '0;
      ld_q     <= '0;
      mis_q    <= 1'b0;
    end else begin
      if (req_start) begin
        dm_addr  <= {ex_addr[AW-1:2], 2'b00};
        dm_we    <= st_we;
        dm_wdata <= st_wdata;
        mis_q    <= 1'b0;
      end
      if (mis_start) begin
        ld_q  <= '0;
        mis_q <= 1'b1;
      end
      if (ld_capture) ld_q <= ld_aligned;
    end
  end

  assign mem_misalign = (state == DONE) & mis_q;
  assign wb_data      = ex_memread ? ld_q : '0;
  assign wb_aluout    = ex_aluout;
  assign wb_rd        = ex_rd;
  assign wb_regwrite  = ex_regwrite;
  assign wb_memtoreg  = ex_memtoreg;
  assign wb_floatwb   = ex_floatwb;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed cases with literal expectations, then randomized accesses
// against a transaction-level model of stall length, bus fields and writeback data.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_memread, ex_memwrite;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata, ex_aluout;
  logic [4:0]  ex_rd;
  logic        ex_regwrite, ex_memtoreg, ex_floatwb;
  logic        dm_req, dm_ready, dm_rvalid;
  logic [3:0]  dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_stall, mem_misalign;
  logic [31:0] wb_data, wb_aluout;
  logic [4:0]  wb_rd;
  logic        wb_regwrite, wb_memtoreg, wb_floatwb;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_stage_lsu #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_aluout(ex_aluout),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_floatwb(ex_floatwb),
    .dm_req(dm_req), .dm_ready(dm_ready), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_stall(mem_stall), .mem_misalign(mem_misalign),
    .wb_data(wb_data), .wb_aluout(wb_aluout), .wb_rd(wb_rd),
    .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_floatwb(wb_floatwb)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---- reference model: plain arithmetic on the access rules ----
  function automatic bit m_mis(input bit [2:0] f3, input bit [31:0] a);
    if (f3 == 3'b001 || f3 == 3'b101) return (a % 2) != 0;
    if (f3 == 3'b010) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic bit [31:0] m_load(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] rd);
    int unsigned v, b, h;
    v = rd >> ((a % 4) * 8);
    b = v % 256;
    h = v % 65536;
    case (f3)
      3'b000:  return (b >= 128) ? 32'(int'(b) - 256) : 32'(b);
      3'b100:  return 32'(b);
      3'b001:  return (h >= 32768) ? 32'(int'(h) - 65536) : 32'(h);
      3'b101:  return 32'(h);
      default: return rd;
    endcase
  endfunction

  function automatic bit [3:0] m_we(input bit [2:0] f3, input bit [31:0] a);
    if (f3[1:0] == 2'b00) return 4'(1 << (a % 4));
    if (f3[1:0] == 2'b01) return 4'(3 << (a % 4));
    return 4'hF;
  endfunction

  function automatic bit [31:0] m_wd(input bit [2:0] f3, input bit [31:0] wd);
    if (f3[1:0] == 2'b00) return (wd % 256) * 32'h01010101;
    if (f3[1:0] == 2'b01) return (wd % 65536) * 32'h00010001;
    return wd;
  endfunction

  // One instruction held in EX/MEM until the stage stops stalling. Called at a negedge.
  task automatic run_txn(input bit ld, input bit st, input bit [2:0] f3, input bit [31:0] a,
                         input bit [31:0] wd, input bit [31:0] rd, input int rlat, input int vlat,
                         output int n_stall, output int n_req, output logic [31:0] o_wb,
                         output logic [3:0] o_we, output logic [31:0] o_wd,
                         output logic [31:0] o_addr, output logic o_mis);
    bit op, mis, hs, done;
    int exp_stall, since_hs;
    logic [31:0] exp_wb;
    op        = ld | st;
    mis       = op && m_mis(f3, a);
    exp_stall = !op ? 0 : (mis ? 1 : 2 + rlat + (ld ? vlat : 0));
    exp_wb    = (ld && !mis) ? m_load(f3, a, rd) : 32'h0;
    ex_valid = 1'b1; ex_memread = ld; ex_memwrite = st; ex_funct3 = f3; ex_addr = a;
    ex_wdata = wd; ex_aluout = $urandom; ex_rd = 5'($urandom);
    ex_regwrite = 1'($urandom); ex_memtoreg = 1'($urandom); ex_floatwb = 1'($urandom);
    n_stall = 0; n_req = 0; hs = 1'b0; since_hs = 0; done = 1'b0;
    o_wb = '0; o_we = '0; o_wd = '0; o_addr = '0; o_mis = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      dm_ready = 1'b0; dm_rvalid = 1'b0; dm_rdata = $urandom;
      #1;
      if (dm_req) begin
        n_req++;
        o_we = dm_we; o_wd = dm_wdata; o_addr = dm_addr;
        chk("dm_addr", dm_addr, a & ~32'h3);
        chk("dm_we", 32'(dm_we), st ? 32'(m_we(f3, a)) : 32'h0);
        if (st) chk("dm_wdata", dm_wdata, m_wd(f3, wd));
        if (n_req == rlat + 1) begin dm_ready = 1'b1; hs = 1'b1; end
      end
      if (hs && ld && since_hs == vlat) begin dm_rvalid = 1'b1; dm_rdata = rd; end
      if (!mem_stall) begin
        done = 1'b1;
        o_wb = wb_data; o_mis = mem_misalign;
        chk("stall_cycles", 32'(n_stall), 32'(exp_stall));
        chk("req_cycles", 32'(n_req), (op && !mis) ? 32'(rlat + 1) : 32'h0);
        chk("wb_data", wb_data, exp_wb);
        chk("misalign", 32'(mem_misalign), 32'(mis));
        chk("wb_aluout", wb_aluout, ex_aluout);
        chk("wb_ctrl", {24'h0, wb_rd, wb_regwrite, wb_memtoreg, wb_floatwb},
            {24'h0, ex_rd, ex_regwrite, ex_memtoreg, ex_floatwb});
      end else begin
        n_stall++;
        chk("misalign_early", 32'(mem_misalign), 32'h0);
      end
      if (hs) since_hs++;
      @(negedge clk);
    end
    if (!done) begin
      miscompares++;
      $display("FAIL timeout: stall never released, got %0d stall cycles expected %0d", n_stall, exp_stall);
    end
    ex_valid = 1'b0; dm_ready = 1'b0; dm_rvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      ex_valid = 1'b0; ex_memread = 1'($urandom); ex_memwrite = 1'($urandom);
      dm_ready = 1'($urandom); dm_rvalid = 1'($urandom); dm_rdata = $urandom;
      #1;
      chk("idle_stall", 32'(mem_stall), 32'h0);
      chk("idle_req", 32'(dm_req), 32'h0);
      @(negedge clk);
    end
    dm_ready = 1'b0; dm_rvalid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ns, nr; logic [31:0] wb, wdv, ad; logic [3:0] we; logic mi;
    bit ld, st; bit [2:0] f3; bit [31:0] a; int k, off;
    bit [2:0] lf3 [5];
    lf3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    rst = 1'b1; ex_valid = 1'b0; ex_memread = 1'b1; ex_memwrite = 1'b0; ex_funct3 = 3'b010;
    ex_addr = 32'h0; ex_wdata = 32'h0; ex_aluout = 32'h0; ex_rd = 5'h0;
    ex_regwrite = 1'b0; ex_memtoreg = 1'b0; ex_floatwb = 1'b0;
    dm_ready = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'h0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_req", 32'(dm_req), 32'h0);
    chk("rst_we", 32'(dm_we), 32'h0);
    chk("rst_addr", dm_addr, 32'h0);
    chk("rst_wdata", dm_wdata, 32'h0);
    chk("rst_misalign", 32'(mem_misalign), 32'h0);
    chk("rst_stall", 32'(mem_stall), 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // LW, ready on second REQ cycle, data one cycle later
    run_txn(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 1, 1, ns, nr, wb, we, wdv, ad, mi);
    chk("lw_stall", 32'(ns), 32'd4);
    chk("lw_wb", wb, 32'hDEADBEEF);
    chk("lw_addr", ad, 32'h100);
    idle(1);
    // SB upper lane, immediate ready
    run_txn(0, 1, 3'b000, 32'h203, 32'h000000A5, 0, 0, 0, ns, nr, wb, we, wdv, ad, mi);
    chk("sb_we", 32'(we), 32'h8);
    chk("sb_wdata", wdv, 32'hA5A5A5A5);
    chk("sb_addr", ad, 32'h200);
    chk("sb_stall", 32'(ns), 32'd2);
    // byte/half extraction
    run_txn(1, 0, 3'b000, 32'h101, 0, 32'h00008000, 0, 1, ns, nr, wb, we, wdv, ad, mi);
    chk("lb_wb", wb, 32'hFFFFFF80);
    run_txn(1, 0, 3'b100, 32'h101, 0, 32'h00008000, 0, 1, ns, nr, wb, we, wdv, ad, mi);
    chk("lbu_wb", wb, 32'h00000080);
    run_txn(1, 0, 3'b101, 32'h102, 0, 32'hBEEF0000, 2, 2, ns, nr, wb, we, wdv, ad, mi);
    chk("lhu_wb", wb, 32'h0000BEEF);
    // misaligned LW
    run_txn(1, 0, 3'b010, 32'h102, 0, 32'h11111111, 0, 0, ns, nr, wb, we, wdv, ad, mi);
    chk("mis_flag", 32'(mi), 32'h1);
    chk("mis_req", 32'(nr), 32'h0);
    chk("mis_wb", wb, 32'h0);
    chk("mis_stall", 32'(ns), 32'd1);
    // ready and rvalid together
    run_txn(1, 0, 3'b010, 32'h300, 0, 32'h12345678, 0, 0, ns, nr, wb, we, wdv, ad, mi);
    chk("fast_stall", 32'(ns), 32'd2);
    chk("fast_wb", wb, 32'h12345678);

    // reset while waiting for read data
    ex_valid = 1'b1; ex_memread = 1'b1; ex_memwrite = 1'b0; ex_funct3 = 3'b010; ex_addr = 32'h100;
    #1 chk("rw_idle_stall", 32'(mem_stall), 32'h1);
    @(negedge clk);
    #1 chk("rw_req", 32'(dm_req), 32'h1);
    dm_ready = 1'b1;
    @(negedge clk);
    dm_ready = 1'b0;
    #1;
    chk("rw_wait_req", 32'(dm_req), 32'h0);
    chk("rw_wait_stall", 32'(mem_stall), 32'h1);
    rst = 1'b1; ex_valid = 1'b0;
    #1;
    chk("rw_rst_req", 32'(dm_req), 32'h0);
    chk("rw_rst_stall", 32'(mem_stall), 32'h0);
    chk("rw_rst_addr", dm_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_txn(1, 0, 3'b010, 32'h104, 0, 32'hCAFEF00D, 1, 2, ns, nr, wb, we, wdv, ad, mi);
    chk("post_rst_stall", 32'(ns), 32'd5);
    chk("post_rst_wb", wb, 32'hCAFEF00D);

    // randomized accesses, back-to-back or separated by idle cycles with bus noise
    for (int t = 0; t < 400; t++) begin
      k  = $urandom_range(0, 9);
      ld = (k >= 1 && k <= 5);
      st = (k >= 6);
      if (ld)      f3 = lf3[$urandom_range(0, 4)];
      else if (st) f3 = 3'($urandom_range(0, 2));
      else         f3 = 3'($urandom);
      a   = $urandom;
      off = $urandom_range(0, 3);
      if ($urandom_range(0, 2) != 0) begin
        if (f3[1:0] == 2'b01) off = off & 2;
        if (f3[1:0] == 2'b10) off = 0;
      end
      a = (a & ~32'h3) | 32'(off);
      run_txn(ld, st, f3, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
              ns, nr, wb, we, wdv, ad, mi);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
